// File: rtl/ifc_pkg.sv
// Shared definitions for the IFC command path: header, command and status codes,
// decoder state encoding and a saturating counter helper.
package ifc_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  localparam logic [3:0] CMD_WR   = 4'h1;
  localparam logic [3:0] CMD_RD   = 4'h2;
  localparam logic [7:0] CMD_PING = 8'h30;

  localparam logic [7:0] ST_OK  = 8'h00;
  localparam logic [7:0] ST_HDR = 8'hE1;
  localparam logic [7:0] ST_CHK = 8'hE2;
  localparam logic [7:0] ST_CMD = 8'hE3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_CHECK,
    S_EXEC,
    S_RESP
  } state_t;

  // Adds 0..3 to an 8-bit counter, clamping at 255.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/ifc_frame_check.sv
// Combinational frame validator: header, then checksum, then command/address,
// reporting the first failing check as a status byte.
module ifc_frame_check
  import ifc_pkg::*;
#(
  parameter logic [7:0] HEADER = HEADER_DEFAULT,
  parameter int         NREG   = 4
) (
  input  logic [31:0] frame,
  output logic [7:0]  status
);

  logic [7:0] hdr;
  logic [7:0] cmd;
  logic [7:0] dat;
  logic [7:0] chk;
  logic       addr_ok;
  logic       cmd_ok;

  assign hdr = frame[31:24];
  assign cmd = frame[23:16];
  assign dat = frame[15:8];
  assign chk = frame[7:0];

  assign addr_ok = ({1'b0, cmd[3:0]} < 5'(NREG));
  assign cmd_ok  = (cmd == CMD_PING) ||
                   (((cmd[7:4] == CMD_WR) || (cmd[7:4] == CMD_RD)) && addr_ok);

  always_comb begin
    status = ST_OK;
    if (hdr != HEADER) begin
      status = ST_HDR;
    end else if (chk != (hdr ^ cmd ^ dat)) begin
      status = ST_CHK;
    end else if (!cmd_ok) begin
      status = ST_CMD;
    end
  end

endmodule

// File: rtl/ifc_cmd_decoder.sv
// IFC command decoder: latches a received frame, validates it, executes
// write/read/ping against a small register file and returns a response frame.
module ifc_cmd_decoder
  import ifc_pkg::*;
#(
  parameter logic [7:0] HEADER = HEADER_DEFAULT,
  parameter int         NREG   = 4
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              frame_flag,
  input  logic [31:0]       frame_data,
  output logic [31:0]       resp_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [NREG*8-1:0] reg_out,
  output logic [7:0]        frame_cnt,
  output logic [7:0]        err_cnt
);

  state_t      state_reg, state_next;
  logic        flag_d_reg;
  logic [31:0] frm_reg;
  logic [7:0]  status_reg;
  logic [31:0] resp_data_reg;
  logic        resp_valid_reg;
  logic [7:0]  frame_cnt_reg;
  logic [7:0]  err_cnt_reg;
  logic [7:0]  regs_reg [NREG];

  logic       start;
  logic       overrun;
  logic [7:0] check_status;
  logic [7:0] cmd;
  logic [3:0] addr;
  logic [7:0] dat;
  logic       exec;
  logic       exec_ok;
  logic       exec_err;
  logic       wr_en;
  logic [7:0] rd_mux;
  logic [7:0] rdat;
  logic [1:0] err_inc;

  assign start   = frame_flag && !flag_d_reg;
  assign overrun = start && (state_reg != S_IDLE);

  assign cmd  = frm_reg[23:16];
  assign addr = frm_reg[19:16];
  assign dat  = frm_reg[15:8];

  assign exec     = (state_reg == S_EXEC);
  assign exec_ok  = exec && (status_reg == ST_OK);
  assign exec_err = exec && (status_reg != ST_OK);
  assign wr_en    = exec_ok && (cmd[7:4] == CMD_WR);
  assign err_inc  = {1'b0, overrun} + {1'b0, exec_err};

  ifc_frame_check #(
    .HEADER (HEADER),
    .NREG   (NREG)
  ) u_check (
    .frame  (frm_reg),
    .status (check_status)
  );

  always_comb begin
    rd_mux = 8'h00;
    for (int k = 0; k < NREG; k++) begin
      if (addr == 4'(k)) rd_mux = regs_reg[k];
    end
  end

  always_comb begin
    rdat = 8'h00;
    if (status_reg == ST_OK) begin
      if (cmd == CMD_PING) rdat = ~dat;
      else if (cmd[7:4] == CMD_RD) rdat = rd_mux;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_LATCH;
      S_LATCH: state_next = S_CHECK;
      S_CHECK: state_next = S_EXEC;
      S_EXEC:  state_next = S_RESP;
      S_RESP:  if (resp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      flag_d_reg     <= 1'b0;
      frm_reg        <= '0;
      status_reg     <= ST_OK;
      resp_data_reg  <= '0;
      resp_valid_reg <= 1'b0;
      frame_cnt_reg  <= '0;
      err_cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      flag_d_reg <= frame_flag;
      if (state_reg == S_LATCH) frm_reg <= frame_data;
      if (state_reg == S_CHECK) status_reg <= check_status;
      if (exec_ok) frame_cnt_reg <= sat_add(frame_cnt_reg, 2'd1);
      if (err_inc != 2'd0) err_cnt_reg <= sat_add(err_cnt_reg, err_inc);
      // resp_data only loads in EXEC, so it cannot move while a response waits.
      if (exec) begin
        resp_data_reg  <= {HEADER, status_reg, rdat, HEADER ^ status_reg ^ rdat};
        resp_valid_reg <= 1'b1;
      end else if ((state_reg == S_RESP) && resp_ready) begin
        resp_valid_reg <= 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_reg[gi] <= 8'h00;
        end else if (wr_en && (addr == 4'(gi))) begin
          regs_reg[gi] <= dat;
        end
      end
      assign reg_out[gi*8 +: 8] = regs_reg[gi];
    end
  endgenerate

  assign resp_data  = resp_data_reg;
  assign resp_valid = resp_valid_reg;
  assign frame_cnt  = frame_cnt_reg;
  assign err_cnt    = err_cnt_reg;

endmodule
